seven_segment_scan_decoder: RTL

Passive monitor for the far end of the seven-segment display interface. It watches the multiplexed `anode`/`LED` pins that `SevenSegmentDisplayDriver` produces and recovers the four displayed hex digits. Each digit is captured once its anode has been stable long enough, and the block publishes a coherent 4-digit frame once per full scan. It sits in self-checking benches and in on-chip loopback/BIST beside the driver.

---
 rtl/seven_segment_scan_decoder_pkg.sv | 45 ++++
 rtl/seg_pattern_decoder.sv | 19 +
 rtl/seven_segment_scan_decoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared types, segment table and reverse lookup for the seven-segment scan decoder.
// The display driver encodes digits with the same table, so loopback frames round-trip exactly.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;   // active-high, bit 6 = a ... bit 0 = g
  typedef logic [3:0] hex_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

  localparam seg_t HEX_TO_SEG [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // Returns {ok, nibble}; any pattern outside the table (blank included) gives {0, 0}.
  function automatic logic [4:0] seg_to_hex(input seg_t seg);
    logic [4:0] res;
    res = 5'b0_0000;
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX_TO_SEG[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational reverse lookup from an active-high segment pattern to a hex nibble.
module seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       ok
);

  logic [4:0] lookup;

  // Table match; unmatched patterns decode to 0 with ok low.
  always_comb begin
    lookup = seg_to_hex(seg);
    nibble = lookup[3:0];
    ok     = lookup[4];
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Passive monitor of a multiplexed seven-segment display: recovers the four shown
// digits and publishes them as one coherent frame per full scan.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no usable anode (blank, multiple, or just broken off)
// SETTLE | one anode active, counting stable cycles before sampling
// HOLD   | current anode already captured, wait for it to go away
module seven_segment_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter int SETTLE_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] anode,
  input  logic [6:0] LED,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_ok,
  output logic       frame_valid,
  output logic       stale,
  output logic       anode_error
);

  localparam logic [7:0]  SETTLE_L = 8'(SETTLE_CYCLES);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] TMO_END  = 20'(TIMEOUT_CYCLES);

  logic [3:0]      anode_q;
  logic [6:0]      led_q;
  logic [3:0]      an_n;
  logic [6:0]      led_n;

  logic            cls_onehot;
  logic            cls_multi;
  logic [1:0]      cls_idx;
  logic            same_digit;

  scan_state_t     state, state_nx;
  logic [7:0]      cnt, cnt_nx;
  logic [1:0]      idx, idx_nx;
  logic            capture;

  logic [3:0]      dec_nib;
  logic            dec_ok;

  logic            multi_prev;
  logic [3:0][3:0] shadow_nib;
  logic [3:0]      shadow_ok;
  logic [3:0]      seen, seen_nx;
  logic [19:0]     timer;
  logic            publish;
  logic            expire;

  // Register the pins once; reset parks them at "nothing lit".
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_q <= ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
      led_q   <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    end else begin
      anode_q <= anode;
      led_q   <= LED;
    end
  end

  assign an_n  = ANODE_ACTIVE_LOW ? ~anode_q : anode_q;
  assign led_n = SEG_ACTIVE_LOW ? ~led_q : led_q;

  // Classify the normalised anode as blank, a single digit index, or multiple.
  always_comb begin
    cls_onehot = 1'b0;
    cls_multi  = 1'b0;
    cls_idx    = 2'd0;
    case (an_n)
      4'b0000: ;
      4'b0001: begin cls_onehot = 1'b1; cls_idx = 2'd0; end
      4'b0010: begin cls_onehot = 1'b1; cls_idx = 2'd1; end
      4'b0100: begin cls_onehot = 1'b1; cls_idx = 2'd2; end
      4'b1000: begin cls_onehot = 1'b1; cls_idx = 2'd3; end
      default: cls_multi = 1'b1;
    endcase
  end

  // In SETTLE/HOLD the previous cycle's anode is always the tracked index.
  assign same_digit = cls_onehot && (cls_idx == idx);

  // FSM state, settle counter and tracked digit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
      idx   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state: any anode change restarts settling on the new digit or drops to IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (cls_multi) begin
      state_nx = ST_IDLE;
      cnt_nx   = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cls_onehot) begin
            state_nx = ST_SETTLE;
            cnt_nx   = 8'd1;
            idx_nx   = cls_idx;
          end
        end
        ST_SETTLE, ST_HOLD: begin
          if (same_digit) begin
            if (state == ST_SETTLE) begin
              if (cnt == SETTLE_L) begin
                state_nx = ST_HOLD;
              end else begin
                cnt_nx = cnt + 8'd1;
              end
            end
          end else if (cls_onehot) begin
            state_nx = ST_SETTLE;
            cnt_nx   = 8'd1;
            idx_nx   = cls_idx;
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = 8'd0;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = 8'd0;
        end
      endcase
    end
  end

  // Outputs of the FSM: a single capture strobe when the settle count is met.
  always_comb begin
    capture = 1'b0;
    if ((state == ST_SETTLE) && same_digit && (cnt == SETTLE_L)) begin
      capture = 1'b1;
    end
  end

  seg_pattern_decoder u_dec (
    .seg    (led_n),
    .nibble (dec_nib),
    .ok     (dec_ok)
  );

  // Pulse anode_error on the first cycle of each multi-anode episode.
  always_ff @(posedge clock) begin
    if (reset) begin
      multi_prev  <= 1'b0;
      anode_error <= 1'b0;
    end else begin
      multi_prev  <= cls_multi;
      anode_error <= cls_multi && !multi_prev;
    end
  end

  // Shadow digits; a recapture of the same index simply overwrites.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_nib <= '0;
      shadow_ok  <= 4'h0;
    end else if (capture) begin
      shadow_nib[idx] <= dec_nib;
      shadow_ok[idx]  <= dec_ok;
    end
  end

  assign publish = (seen == 4'hF);
  // A capture in the expiry cycle keeps the display alive.
  assign expire  = !capture && (timer == TMO_LAST);

  // Seen mask: cleared by a publish or a timeout, then marked by this cycle's capture.
  always_comb begin
    seen_nx = seen;
    if (publish || expire) begin
      seen_nx = 4'h0;
    end
    if (capture) begin
      seen_nx[idx] = 1'b1;
    end
  end

  // Seen mask register.
  always_ff @(posedge clock) begin
    if (reset) begin
      seen <= 4'h0;
    end else begin
      seen <= seen_nx;
    end
  end

  // Publish all shadows together the cycle after the mask fills.
  always_ff @(posedge clock) begin
    if (reset) begin
      digit0      <= 4'h0;
      digit1      <= 4'h0;
      digit2      <= 4'h0;
      digit3      <= 4'h0;
      digit_ok    <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        digit0   <= shadow_nib[0];
        digit1   <= shadow_nib[1];
        digit2   <= shadow_nib[2];
        digit3   <= shadow_nib[3];
        digit_ok <= shadow_ok;
      end
    end
  end

  // Capture-to-capture timer; saturates once expired so stale is raised only once.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= 20'd0;
    end else if (capture) begin
      timer <= 20'd0;
    end else if (timer != TMO_END) begin
      timer <= timer + 20'd1;
    end
  end

  // Stale flag: set on expiry, cleared by the next published frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      stale <= 1'b0;
    end else if (expire) begin
      stale <= 1'b1;
    end else if (publish) begin
      stale <= 1'b0;
    end
  end

endmodule
